mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
- Parametrised byte-serial memory controller that replaces the fixed two-client (ifetch + LSB) controller.
- Serves NCH request channels over the single 8-bit external memory port.
- Supports per-channel burst lengths up to MAX_BYTES, configurable arbitration, and per-channel abort of reads on rollback.
- Sits between the front-end/LSB/other clients and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- NCH, 2, number of request channels; channel 0 has highest fixed priority.
- MAX_BYTES, 16, maximum read burst in bytes; must be at least 4.
- LEN_W, 5, width of each channel length field; must satisfy 2^LEN_W > MAX_BYTES.
- ABORT_MASK, 2'b10, bit i set means channel i reads are cancelled by rollback.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global ready; low freezes the block.
- rollback  in  1  pipeline flush.
- mem_in  in  8  read byte, valid one cycle after its address.
- mem_out  out  8  write byte.
- mem_addr  out  32  byte address.
- mem_rw  out  1  1 = write.
- req_en  in  NCH  per-channel request, held until done.
- req_rw  in  NCH  per-channel 1 = write.
- req_addr  in  NCH*32  start address, channel i at bits [32i+31:32i].
- req_len  in  NCH*LEN_W  byte count; writes 1..4, reads 1..MAX_BYTES.
- req_wdata  in  NCH*32  write data, little-endian.
- done  out  NCH  one-cycle completion pulse, per channel.
- rdata  out  MAX_BYTES*8  read data, byte k at [8k+7:8k]; valid in the done cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; mem_rw=0; mem_addr=0; mem_out=0; done=0; rdata=0; round-robin pointer=0.
- rdy=0: all registers hold, including state, position counter, mem_addr and mem_rw, so the current byte stays outstanding. The block resumes exactly where it stopped when rdy returns to 1.
- States are IDLE, READ, WRITE, GAP.
- IDLE:
  - If any req_en bit is set and rollback=0, grant one channel.
  - Latch that channel's addr/len/rw/wdata and clear rdata to 0.
  - Grant with len=0: go to GAP, pulse done, no memory access.
  - Grant for a read: mem_addr <= addr, go to READ.
  - Grant for a write: go to WRITE.
- READ:
  - Byte k (k = 0..L-1) is presented at mem_addr in the cycle after grant+k.
  - mem_in is captured into rdata byte k one cycle later.
  - After the last address is issued, mem_addr <= 0.
  - done pulses exactly L+1 cycles after the grant edge, then the state goes to GAP.
  - rdata bytes at index ≥ L read 0.
- WRITE:
  - For k = 0..L-1, drive mem_rw=1, mem_addr=addr+k, mem_out=wdata byte k, one byte per cycle.
  - In the cycle after the last byte, mem_rw=0, mem_addr=0 and done pulses; the state goes to GAP.
  - Writes are never aborted.
- GAP: done is deasserted and the state returns to IDLE. There is no grant in this cycle, so the client can drop req_en.
- Rollback:
  - In READ for a channel whose ABORT_MASK bit is set: abort immediately, mem_addr <= 0, no done pulse, go to IDLE.
  - In READ for a channel whose ABORT_MASK bit is clear: no effect.
  - In IDLE: suppresses grants for that cycle.
  - In WRITE: ignored.
- Address arithmetic: 32-bit, wraps modulo 2^32.
- Simultaneous requests are resolved by the arbitration policy (see Optional Feature).
- A request that drops req_en before grant is not served.
- req_* inputs are sampled only at grant; later changes are ignored.
- At most one done bit is high in any cycle.

Optional Feature:
- ROUND_ROBIN_EN defined:
  - Round-robin grant starting from the channel after the last granted one.
  - The pointer updates on every grant, including len=0 grants.
  - The pointer is not updated on aborts.
- ROUND_ROBIN_EN undefined:
  - Fixed priority; the lowest-index requesting channel wins.
  - The pointer logic is absent.

Test Plan:
- Read, ch0, addr 0x100, len 4, memory bytes 11 22 33 44 -> mem_addr steps 0x100..0x103; done[0] pulses at grant+5 with rdata[31:0]=0x44332211; upper rdata bytes are 0.
- Write, ch1, addr 0x20, len 2, wdata 0xBEEF -> mem_rw=1 for 2 cycles, (0x20,EF) then (0x21,BE); done[1] in the next cycle; mem_rw=0 afterwards.
- Both channels request in the same IDLE cycle, twice in a row:
  - Fixed priority: ch0 is served first both times.
  - ROUND_ROBIN_EN: the order is ch0, ch1, ch0.
- ch1 read len 16, rollback at byte 5 with ABORT_MASK=2'b10 -> mem_addr=0 next cycle, no done, IDLE; the same scenario on ch0 completes normally.
- rdy low for 3 cycles mid-read at byte 2 -> mem_addr held; the final rdata is identical to an unstalled run; done is delayed by exactly 3 cycles.
- rst_n asserted mid-write -> mem_rw=0, done=0, mem_addr=0 immediately without waiting for clk; the next request is served from IDLE.

Source files
------------

// File: rtl/mem_arbiter_ctrl_if.sv
// Client request channels plus the byte-serial external memory port of mem_arbiter_ctrl.
// slave is the controller side, master is the client/memory side.
interface mem_arbiter_ctrl_if #(
  parameter int NCH       = 2,
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = 5
);
  logic [7:0]             mem_in;
  logic [7:0]             mem_out;
  logic [31:0]            mem_addr;
  logic                   mem_rw;
  logic [NCH-1:0]         req_en;
  logic [NCH-1:0]         req_rw;
  logic [NCH*32-1:0]      req_addr;
  logic [NCH*LEN_W-1:0]   req_len;
  logic [NCH*32-1:0]      req_wdata;
  logic [NCH-1:0]         done;
  logic [MAX_BYTES*8-1:0] rdata;

  modport slave (
    input  mem_in, req_en, req_rw, req_addr, req_len, req_wdata,
    output mem_out, mem_addr, mem_rw, done, rdata
  );

  modport master (
    output mem_in, req_en, req_rw, req_addr, req_len, req_wdata,
    input  mem_out, mem_addr, mem_rw, done, rdata
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// NCH-channel byte-serial memory controller with burst reads, short writes and read abort.
// Define ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest channel index wins.
module mem_arbiter_ctrl #(
  parameter int             NCH        = 2,
  parameter int             MAX_BYTES  = 16,
  parameter int             LEN_W      = 5,
  parameter logic [NCH-1:0] ABORT_MASK = NCH'(2'b10)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              rollback,
  mem_arbiter_ctrl_if.slave bus
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, GAP} state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [7:0]             mem_out_q, mem_out_d;
  logic                   mem_rw_q, mem_rw_d;
  logic [NCH-1:0]         done_q, done_d;
  logic [MAX_BYTES*8-1:0] rdata_q, rdata_d;

  logic                   gnt_vld;
  logic [CH_W-1:0]        gnt_idx;
  logic [CH_W-1:0]        gnt_next;
  logic [LEN_W-1:0]       gnt_len;
  logic                   gnt_rw;
  logic [7:0]             wbyte;
  int                     byte_idx;

`ifdef ROUND_ROBIN_EN
  logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
  int                     rr_idx;

  // Search from the pointer upward; iterating backwards lets the nearest requester win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    for (int off = NCH-1; off >= 0; off--) begin
      rr_idx = (int'(rr_ptr_q) + off) % NCH;
      if (bus.req_en[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(rr_idx);
      end
    end
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (bus.req_en[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(i);
      end
    end
  end
`endif

  always_comb begin
    gnt_next = (int'(gnt_idx) == NCH-1) ? '0 : gnt_idx + CH_W'(1);
    gnt_rw   = bus.req_rw[gnt_idx];
    gnt_len  = bus.req_len[LEN_W*gnt_idx +: LEN_W];
    // Out-of-range lengths are clamped so a bad client cannot overrun rdata or wdata.
    if (gnt_rw && gnt_len > LEN_W'(4)) begin
      gnt_len = LEN_W'(4);
    end else if (!gnt_rw && gnt_len > LEN_W'(MAX_BYTES)) begin
      gnt_len = LEN_W'(MAX_BYTES);
    end
  end

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  // Next-state logic; with rdy low every register keeps its value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ch_d       = ch_q;
    mem_addr_d = mem_addr_q;
    mem_out_d  = mem_out_q;
    mem_rw_d   = mem_rw_q;
    done_d     = done_q;
    rdata_d    = rdata_q;
    byte_idx   = 0;
`ifdef ROUND_ROBIN_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    if (rdy) begin
      done_d = '0;
      case (state_q)
        IDLE: begin
          if (gnt_vld && !rollback) begin
            ch_d    = gnt_idx;
            len_d   = gnt_len;
            addr_d  = bus.req_addr[32*gnt_idx +: 32];
            wdata_d = bus.req_wdata[32*gnt_idx +: 32];
            cnt_d   = '0;
            rdata_d = '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr_d = gnt_next;
`endif
            if (gnt_len == '0) begin
              done_d[gnt_idx] = 1'b1;
              state_d         = GAP;
            end else if (gnt_rw) begin
              state_d = WRITE;
            end else begin
              mem_addr_d = bus.req_addr[32*gnt_idx +: 32];
              state_d    = READ;
            end
          end
        end
        READ: begin
          if (rollback && ABORT_MASK[ch_q]) begin
            mem_addr_d = '0;
            state_d    = IDLE;
          end else begin
            // Data for the address issued one cycle earlier is on mem_in now.
            if (cnt_q != '0) begin
              byte_idx = int'(cnt_q) - 1;
              if (byte_idx < MAX_BYTES) begin
                rdata_d[8*byte_idx +: 8] = bus.mem_in;
              end
            end
            if (cnt_q == len_q) begin
              done_d[ch_q] = 1'b1;
              state_d      = GAP;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
              if (cnt_d < len_q) begin
                mem_addr_d = addr_q + 32'(cnt_d);
              end else begin
                mem_addr_d = '0;
              end
            end
          end
        end
        WRITE: begin
          if (cnt_q == len_q) begin
            mem_rw_d     = 1'b0;
            mem_addr_d   = '0;
            mem_out_d    = '0;
            done_d[ch_q] = 1'b1;
            state_d      = GAP;
          end else begin
            mem_rw_d   = 1'b1;
            mem_addr_d = addr_q + 32'(cnt_q);
            mem_out_d  = wbyte;
            cnt_d      = cnt_q + LEN_W'(1);
          end
        end
        GAP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ch_q       <= '0;
      mem_addr_q <= '0;
      mem_out_q  <= '0;
      mem_rw_q   <= 1'b0;
      done_q     <= '0;
      rdata_q    <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ch_q       <= ch_d;
      mem_addr_q <= mem_addr_d;
      mem_out_q  <= mem_out_d;
      mem_rw_q   <= mem_rw_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_out  = mem_out_q;
  assign bus.mem_rw   = mem_rw_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: reads, writes, arbitration, abort, stall and reset.
// Expected values are hand-derived from a fixed memory image; ROUND_ROBIN_EN changes the arbitration order.
module tb_mem_arbiter_ctrl;

  logic clk;
  logic rst_n;
  logic rdy;
  logic rollback;

  int checks;
  int failures;

  logic [1:0] seen;
  logic [1:0] doneAcc;
  logic [31:0] addrAcc;
  logic ok;
  int cyc;
  int cyc2;

  mem_arbiter_ctrl_if #(.NCH(2), .MAX_BYTES(16), .LEN_W(5)) bus ();

  mem_arbiter_ctrl #(
    .NCH(2), .MAX_BYTES(16), .LEN_W(5), .ABORT_MASK(2'b10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rdy(rdy),
    .rollback(rollback),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0x1xx returns 11,22,33,44 by low address bits; everything else returns addr[7:0]+0x80.
  function automatic logic [7:0] memByte(input logic [31:0] a);
    if (a[11:8] == 4'h1) memByte = 8'h11 * ({6'b0, a[1:0]} + 8'd1);
    else memByte = a[7:0] + 8'h80;
  endfunction

  // The memory shares the global ready, so it freezes along with the controller.
  always @(posedge clk) begin
    if (rdy) bus.mem_in <= memByte(bus.mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic rw, input logic [31:0] addr,
                               input logic [4:0] len, input logic [31:0] wdata);
    bus.req_en[ch]            = 1'b1;
    bus.req_rw[ch]            = rw;
    bus.req_addr[32*ch +: 32] = addr;
    bus.req_len[5*ch +: 5]    = len;
    bus.req_wdata[32*ch +: 32] = wdata;
  endtask

  task automatic dropRequests();
    bus.req_en = '0;
  endtask

  task automatic waitDone(input int budget, output logic [1:0] s, output int cycles);
    s = '0;
    cycles = 0;
    while (s == '0 && cycles < budget) begin
      tick();
      cycles++;
      s = bus.done;
    end
  endtask

  task automatic waitAddr(input logic [31:0] target, input int budget, output logic found, output int cycles);
    found = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      tick();
      cycles++;
      found = (bus.mem_addr == target);
    end
  endtask

  task automatic waitRw(input int budget, output logic found);
    int n;
    n = 0;
    found = 1'b0;
    while (!found && n < budget) begin
      tick();
      n++;
      found = bus.mem_rw;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    rdy = 1'b1;
    rollback = 1'b0;
    bus.mem_in = '0;
    bus.req_en = '0;
    bus.req_rw = '0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.req_wdata = '0;

    #23;
    checkOutput("rst_mem_rw", 128'(bus.mem_rw), 128'd0);
    checkOutput("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    checkOutput("rst_mem_out", 128'(bus.mem_out), 128'd0);
    checkOutput("rst_done", 128'(bus.done), 128'd0);
    checkOutput("rst_rdata", bus.rdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] read ch0 0x100 len 4");
    applyStimulus(0, 1'b0, 32'h100, 5'd4, 32'h0);
    tick();
    checkOutput("rd_addr0", 128'(bus.mem_addr), 128'h100);
    tick();
    checkOutput("rd_addr1", 128'(bus.mem_addr), 128'h101);
    tick();
    checkOutput("rd_addr2", 128'(bus.mem_addr), 128'h102);
    tick();
    checkOutput("rd_addr3", 128'(bus.mem_addr), 128'h103);
    tick();
    checkOutput("rd_addr_clear", 128'(bus.mem_addr), 128'd0);
    checkOutput("rd_no_early_done", 128'(bus.done), 128'd0);
    tick();
    checkOutput("rd_done", 128'(bus.done), 128'h1);
    checkOutput("rd_data", bus.rdata, 128'h44332211);
    dropRequests();
    tick();
    checkOutput("rd_done_single", 128'(bus.done), 128'd0);

    $display("[TB] write ch1 0x20 len 2");
    applyStimulus(1, 1'b1, 32'h20, 5'd2, 32'h0000BEEF);
    waitRw(6, ok);
    checkOutput("wr_start", 128'(ok), 128'd1);
    checkOutput("wr_b0_addr", 128'(bus.mem_addr), 128'h20);
    checkOutput("wr_b0_data", 128'(bus.mem_out), 128'hEF);
    tick();
    checkOutput("wr_b1_rw", 128'(bus.mem_rw), 128'd1);
    checkOutput("wr_b1_addr", 128'(bus.mem_addr), 128'h21);
    checkOutput("wr_b1_data", 128'(bus.mem_out), 128'hBE);
    tick();
    checkOutput("wr_end_rw", 128'(bus.mem_rw), 128'd0);
    checkOutput("wr_end_addr", 128'(bus.mem_addr), 128'd0);
    checkOutput("wr_done", 128'(bus.done), 128'h2);
    dropRequests();
    tick();
    checkOutput("wr_after_rw", 128'(bus.mem_rw), 128'd0);
    checkOutput("wr_after_done", 128'(bus.done), 128'd0);

    $display("[TB] simultaneous requests");
    applyStimulus(0, 1'b0, 32'h100, 5'd1, 32'h0);
    applyStimulus(1, 1'b0, 32'h200, 5'd1, 32'h0);
    waitDone(20, seen, cyc);
    checkOutput("arb_first", 128'(seen), 128'h1);
    checkOutput("arb_first_data", bus.rdata, 128'h11);
    waitDone(20, seen, cyc);
`ifdef ROUND_ROBIN_EN
    checkOutput("arb_second", 128'(seen), 128'h2);
`else
    checkOutput("arb_second", 128'(seen), 128'h1);
`endif
    waitDone(20, seen, cyc);
    checkOutput("arb_third", 128'(seen), 128'h1);
    dropRequests();
    tick();

    $display("[TB] zero-length grant");
    applyStimulus(1, 1'b0, 32'h500, 5'd0, 32'h0);
    tick();
    checkOutput("len0_done", 128'(bus.done), 128'h2);
    checkOutput("len0_addr", 128'(bus.mem_addr), 128'd0);
    checkOutput("len0_rdata", bus.rdata, 128'd0);
    dropRequests();
    tick();
    checkOutput("len0_done_single", 128'(bus.done), 128'd0);

    $display("[TB] rollback on abortable ch1");
    applyStimulus(1, 1'b0, 32'h300, 5'd16, 32'h0);
    waitAddr(32'h305, 30, ok, cyc);
    checkOutput("abort_reach_b5", 128'(ok), 128'd1);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    dropRequests();
    checkOutput("abort_addr", 128'(bus.mem_addr), 128'd0);
    checkOutput("abort_done", 128'(bus.done), 128'd0);
    doneAcc = '0;
    addrAcc = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      doneAcc |= bus.done;
      addrAcc |= bus.mem_addr;
    end
    checkOutput("abort_no_done", 128'(doneAcc), 128'd0);
    checkOutput("abort_bus_quiet", 128'(addrAcc), 128'd0);

    $display("[TB] rollback on non-abortable ch0");
    applyStimulus(0, 1'b0, 32'h300, 5'd16, 32'h0);
    tick();
    checkOutput("noabort_grant", 128'(bus.mem_addr), 128'h300);
    waitAddr(32'h305, 30, ok, cyc);
    checkOutput("noabort_reach_b5", 128'(ok), 128'd1);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    checkOutput("noabort_addr", 128'(bus.mem_addr), 128'h306);
    waitDone(30, seen, cyc2);
    checkOutput("noabort_done", 128'(seen), 128'h1);
    checkOutput("noabort_latency", 128'(cyc + 1 + cyc2), 128'd17);
    checkOutput("noabort_data", bus.rdata, 128'h8F8E8D8C_8B8A8988_87868584_83828180);
    dropRequests();
    tick();

    $display("[TB] rdy stall mid-read");
    applyStimulus(0, 1'b0, 32'h3A0, 5'd6, 32'h0);
    tick();
    checkOutput("stall_grant", 128'(bus.mem_addr), 128'h3A0);
    waitAddr(32'h3A2, 10, ok, cyc);
    checkOutput("stall_reach_b2", 128'(ok), 128'd1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_hold_addr", 128'(bus.mem_addr), 128'h3A2);
    end
    rdy = 1'b1;
    waitDone(20, seen, cyc2);
    checkOutput("stall_done", 128'(seen), 128'h1);
    checkOutput("stall_latency", 128'(cyc + 3 + cyc2), 128'd10);
    checkOutput("stall_data", bus.rdata, 128'h252423222120);
    dropRequests();
    tick();

    $display("[TB] reset during write");
    applyStimulus(1, 1'b1, 32'h40, 5'd4, 32'hDEADBEEF);
    waitRw(6, ok);
    checkOutput("rstw_start", 128'(ok), 128'd1);
    tick();
    checkOutput("rstw_b1_addr", 128'(bus.mem_addr), 128'h41);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_rw", 128'(bus.mem_rw), 128'd0);
    checkOutput("rstw_addr", 128'(bus.mem_addr), 128'd0);
    checkOutput("rstw_done", 128'(bus.done), 128'd0);
    checkOutput("rstw_out", 128'(bus.mem_out), 128'd0);
    dropRequests();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(0, 1'b0, 32'h100, 5'd2, 32'h0);
    tick();
    checkOutput("rstw_next_grant", 128'(bus.mem_addr), 128'h100);
    waitDone(10, seen, cyc);
    checkOutput("rstw_next_done", 128'(seen), 128'h1);
    checkOutput("rstw_next_latency", 128'(cyc), 128'd3);
    checkOutput("rstw_next_data", bus.rdata, 128'h2211);
    dropRequests();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
